// File: rtl/line_pingpong_buffer_if.sv
// line_pingpong_buffer_if: write, readout and status bundle of line_pingpong_buffer; MIRROR exists only with LINE_MIRROR_EN
interface line_pingpong_buffer_if #(
  parameter int DATA_W = 14,
  parameter int NUM_CHAN = 2,
  parameter int ADDR_W = 10
);
  logic WR_START;
  logic WR_EN;
  logic [NUM_CHAN*DATA_W-1:0] DATA_IN;
  logic RD_MODE;
  logic RD_START;
  logic RD_REQ;
  logic [ADDR_W-1:0] RD_ADDR;
  logic RD_RELEASE;
  logic OUT_READY;
  logic OUT_VALID;
  logic [DATA_W-1:0] OUT_DATA;
  logic OUT_LAST;
  logic LINE_READY;
  logic RD_HOLD;
  logic WR_BANK;
  logic OVERFLOW;
`ifdef LINE_MIRROR_EN
  logic MIRROR;
`endif
  modport master (
`ifdef LINE_MIRROR_EN
    output MIRROR,
`endif
    output WR_START, WR_EN, DATA_IN, RD_MODE, RD_START, RD_REQ, RD_ADDR, RD_RELEASE, OUT_READY,
    input OUT_VALID, OUT_DATA, OUT_LAST, LINE_READY, RD_HOLD, WR_BANK, OVERFLOW
  );
  modport slave (
`ifdef LINE_MIRROR_EN
    input MIRROR,
`endif
    input WR_START, WR_EN, DATA_IN, RD_MODE, RD_START, RD_REQ, RD_ADDR, RD_RELEASE, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_LAST, LINE_READY, RD_HOLD, WR_BANK, OVERFLOW
  );
endinterface

// File: rtl/line_pingpong_buffer.sv
// line_pingpong_buffer: ping-pong line buffer, multi-channel fill side, stream or random readout; LINE_MIRROR_EN adds MIRROR
module line_pingpong_buffer #(
  parameter int DATA_W = 14,
  parameter int PIX_PER_ROW = 640,
  parameter int NUM_CHAN = 2,
  parameter int ADDR_W = 10
) (
  input logic CLK,
  input logic RESET,
  line_pingpong_buffer_if.slave bus
);
  localparam int IDX_W = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(PIX_PER_ROW - 1);
  localparam logic [ADDR_W:0] PIX_X = (ADDR_W+1)'(PIX_PER_ROW);
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_RANDOM} rstate_t;
  logic [DATA_W-1:0] mem [2][PIX_PER_ROW];
  logic [ADDR_W-1:0] wr_cnt, base, ptr, ptr_n;
  logic [ADDR_W:0] cnt_nx;
  logic wr_done, wr_bank, rd_hold, line_ready, overflow, swap, wr_ok, hold_clr;
  logic out_valid, valid_n, zero, zero_n, mir, mir_n, mir_in, last;
  rstate_t state, state_n;
`ifdef LINE_MIRROR_EN
  assign mir_in = bus.MIRROR;
`else
  assign mir_in = 1'b0;
`endif
  // a completed line moves to the read side as soon as the read bank is free
  always_comb begin
    swap = wr_done && !rd_hold;
    base = bus.WR_START ? '0 : wr_cnt;
    cnt_nx = {1'b0, base} + (ADDR_W+1)'(NUM_CHAN);
    wr_ok = bus.WR_EN && !swap && (bus.WR_START || !wr_done);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wr_cnt <= '0;
      wr_done <= 1'b0;
      wr_bank <= 1'b0;
      rd_hold <= 1'b0;
      line_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      line_ready <= swap;
      if (bus.WR_EN && !wr_ok) overflow <= 1'b1;
      if (swap) begin
        wr_bank <= !wr_bank;
        rd_hold <= 1'b1;
        wr_cnt <= '0;
        wr_done <= 1'b0;
      end else begin
        if (hold_clr) rd_hold <= 1'b0;
        if (wr_ok) begin
          wr_cnt <= cnt_nx[ADDR_W-1:0];
          wr_done <= cnt_nx == PIX_X;
        end else if (bus.WR_START) begin
          wr_cnt <= '0;
          wr_done <= 1'b0;
        end
      end
    end
  always_ff @(posedge CLK)
    if (wr_ok)
      for (int k = 0; k < NUM_CHAN; k++)
        mem[wr_bank][IDX_W'(base + ADDR_W'(k))] <= bus.DATA_IN[k*DATA_W +: DATA_W];
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    valid_n = out_valid;
    zero_n = zero;
    mir_n = mir;
    hold_clr = 1'b0;
    last = mir ? ptr == '0 : ptr == LAST_A;
    case (state)
      R_IDLE: begin
        valid_n = 1'b0;
        zero_n = 1'b0;
        if (rd_hold && bus.RD_MODE) begin
          state_n = R_RANDOM;
          mir_n = mir_in;
        end else if (rd_hold && bus.RD_START) begin
          state_n = R_STREAM;
          valid_n = 1'b1;
          mir_n = mir_in;
          ptr_n = mir_in ? LAST_A : '0;
        end
      end
      R_STREAM:
        if (out_valid && bus.OUT_READY) begin
          if (last) begin
            state_n = R_IDLE;
            valid_n = 1'b0;
            hold_clr = 1'b1;
          end else ptr_n = mir ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
        end
      R_RANDOM: begin
        valid_n = bus.RD_REQ;
        if (bus.RD_REQ) begin
          ptr_n = mir ? LAST_A - bus.RD_ADDR : bus.RD_ADDR;
          zero_n = {1'b0, bus.RD_ADDR} >= PIX_X;
        end
        if (bus.RD_RELEASE) begin
          state_n = R_IDLE;
          hold_clr = 1'b1;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= R_IDLE;
      ptr <= '0;
      out_valid <= 1'b0;
      zero <= 1'b0;
      mir <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      out_valid <= valid_n;
      zero <= zero_n;
      mir <= mir_n;
    end
  // read bank is stable while RD_HOLD is set, so the pixel is read straight from the held pointer
  assign bus.OUT_DATA = (out_valid && !zero) ? mem[~wr_bank][ptr[IDX_W-1:0]] : '0;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_LAST = out_valid && state == R_STREAM && last;
  assign bus.LINE_READY = line_ready;
  assign bus.RD_HOLD = rd_hold;
  assign bus.WR_BANK = wr_bank;
  assign bus.OVERFLOW = overflow;
endmodule

// File: tb/tb_line_pingpong_buffer.sv
// tb_line_pingpong_buffer: directed and randomized checks against a FIFO-of-lines reference model
module tb_line_pingpong_buffer;
  localparam int DW = 14;
  localparam int PIX = 8;
  localparam int NC = 2;
  localparam int AW = 4;
  typedef logic [PIX-1:0][DW-1:0] line_t;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int total = 0;
  int bad = 0;
  int lr_cnt = 0;
  int lr0;
  bit exp_bank = 1'b0;
  line_t lines[$];
  line_t ln, e;
  logic [DW-1:0] exp_d;
  int a;
  line_pingpong_buffer_if #(.DATA_W(DW), .NUM_CHAN(NC), .ADDR_W(AW)) bus();
  line_pingpong_buffer #(.DATA_W(DW), .PIX_PER_ROW(PIX), .NUM_CHAN(NC), .ADDR_W(AW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (bus.LINE_READY === 1'b1) lr_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  function automatic line_t rnd_line;
    line_t r;
    for (int i = 0; i < PIX; i++) r[i] = DW'($urandom);
    return r;
  endfunction
  task automatic junk_beats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.WR_EN = 1'b1;
      bus.DATA_IN = (NC*DW)'({$urandom, $urandom, $urandom, $urandom});
      tick;
    end
    bus.WR_EN = 1'b0;
  endtask
  task automatic fill(input line_t l, input bit st);
    for (int n = 0; n < PIX/NC; n++) begin
      bus.WR_EN = 1'b1;
      bus.WR_START = st && n == 0;
      for (int k = 0; k < NC; k++) bus.DATA_IN[k*DW +: DW] = l[n*NC + k];
      tick;
    end
    bus.WR_EN = 1'b0;
    bus.WR_START = 1'b0;
  endtask
  task automatic wait_lr(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick;
      seen = bus.LINE_READY === 1'b1;
    end
    exp_bank = !exp_bank;
    chk(tag, seen, 1'b1);
    chk("swap_hold", bus.RD_HOLD, 1'b1);
    chk("swap_bank", bus.WR_BANK, exp_bank);
  endtask
  task automatic stream(input int mode);
    line_t x;
    int idx = 0;
    int c = 0;
    bit rdy;
    x = lines.pop_front();
    bus.RD_START = 1'b1;
    tick;
    bus.RD_START = 1'b0;
    while (idx < PIX && c < 100) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom);
      bus.OUT_READY = rdy;
      chk("s_valid", bus.OUT_VALID, 1'b1);
      chk("s_data", bus.OUT_DATA, x[idx]);
      chk("s_last", bus.OUT_LAST, 1'(idx == PIX-1));
      tick;
      c++;
      if (rdy) idx++;
    end
    bus.OUT_READY = 1'b0;
    chk("s_count", idx, PIX);
    if (mode == 0) chk("s_cycles", c, PIX);
    chk("s_end_valid", bus.OUT_VALID, 1'b0);
    chk("s_end_hold", bus.RD_HOLD, 1'b0);
  endtask
  initial begin
    bus.WR_START = 0; bus.WR_EN = 0; bus.DATA_IN = '0; bus.RD_MODE = 0; bus.RD_START = 0;
    bus.RD_REQ = 0; bus.RD_ADDR = '0; bus.RD_RELEASE = 0; bus.OUT_READY = 0;
`ifdef LINE_MIRROR_EN
    bus.MIRROR = 1'b0;
`endif
    #1 RESET = 1'b1;
    #1;
    chk("rst_valid", bus.OUT_VALID, 1'b0);
    chk("rst_data", bus.OUT_DATA, 14'd0);
    chk("rst_last", bus.OUT_LAST, 1'b0);
    chk("rst_lr", bus.LINE_READY, 1'b0);
    chk("rst_hold", bus.RD_HOLD, 1'b0);
    chk("rst_bank", bus.WR_BANK, 1'b0);
    chk("rst_ovf", bus.OVERFLOW, 1'b0);
    tick;
    RESET = 1'b0;
    for (int i = 0; i < PIX; i++) ln[i] = DW'(i);
    lr0 = lr_cnt;
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_first");
    tick;
    tick;
    chk("lr_once", lr_cnt - lr0, 1);
    chk("no_ovf", bus.OVERFLOW, 1'b0);
    stream(0);
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_bp1");
    stream(1);
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_bp2");
    stream(2);
    lr0 = lr_cnt;
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_a");
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    junk_beats(1);
    chk("ovf_set", bus.OVERFLOW, 1'b1);
    tick;
    tick;
    tick;
    chk("ovf_no_lr", lr_cnt - lr0, 1);
    stream(0);
    wait_lr("lr_b");
    stream(2);
    chk("ovf_sticky", bus.OVERFLOW, 1'b1);
    for (int i = 0; i < PIX; i++) ln[i] = DW'(i);
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_rand");
    e = lines.pop_front();
    bus.RD_MODE = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      a = i == 0 ? 5 : i == 1 ? 9 : int'($urandom_range(0, 15));
      exp_d = '0;
      if (a < PIX) exp_d = e[a];
      bus.RD_REQ = 1'b1;
      bus.RD_ADDR = AW'(a);
      tick;
      bus.RD_REQ = 1'b0;
      chk("r_valid", bus.OUT_VALID, 1'b1);
      chk("r_data", bus.OUT_DATA, exp_d);
      tick;
      chk("r_gap_valid", bus.OUT_VALID, 1'b0);
      chk("r_gap_data", bus.OUT_DATA, 14'd0);
    end
    bus.RD_REQ = 1'b1;
    bus.RD_RELEASE = 1'b1;
    bus.RD_ADDR = AW'(3);
    tick;
    bus.RD_REQ = 1'b0;
    bus.RD_RELEASE = 1'b0;
    bus.RD_MODE = 1'b0;
    chk("rel_valid", bus.OUT_VALID, 1'b1);
    chk("rel_data", bus.OUT_DATA, e[3]);
    chk("rel_hold", bus.RD_HOLD, 1'b0);
    tick;
    chk("rel_after", bus.OUT_VALID, 1'b0);
    junk_beats(2);
    bus.WR_START = 1'b1;
    tick;
    bus.WR_START = 1'b0;
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_restart");
    stream(1);
    junk_beats(3);
    ln = rnd_line();
    fill(ln, 1'b1);
    lines.push_back(ln);
    wait_lr("lr_restart2");
    stream(0);
    ln = rnd_line();
    fill(ln, 1'b0);
    wait_lr("lr_pre_rst");
    bus.OUT_READY = 1'b1;
    bus.RD_START = 1'b1;
    tick;
    bus.RD_START = 1'b0;
    tick;
    tick;
    chk("pre_rst_valid", bus.OUT_VALID, 1'b1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_valid", bus.OUT_VALID, 1'b0);
    chk("mid_rst_data", bus.OUT_DATA, 14'd0);
    chk("mid_rst_hold", bus.RD_HOLD, 1'b0);
    chk("mid_rst_bank", bus.WR_BANK, 1'b0);
    chk("mid_rst_ovf", bus.OVERFLOW, 1'b0);
    exp_bank = 1'b0;
    bus.OUT_READY = 1'b0;
    tick;
    RESET = 1'b0;
    ln = rnd_line();
    fill(ln, 1'b0);
    lines.push_back(ln);
    wait_lr("lr_post_rst");
    stream(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
